// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: queues fetch pairs and issues up to two
// instructions per cycle, holding back any that hit RAW/WAW hazards.
module dual_issue_scheduler #(
  parameter int HIST_DEPTH = 3,
  parameter int QDEPTH     = 4,
  parameter bit DUAL_EN    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [15:0]                  instr0_in,
  input  logic [15:0]                  instr1_in,
  input  logic                         flush,
  output logic [15:0]                  issue0,
  output logic [15:0]                  issue1,
  output logic                         stall,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  localparam int CW = $clog2(QDEPTH+1);
  localparam int PW = $clog2(QDEPTH);

  function automatic logic is_nop(input logic [15:0] i);
    return i[15:12] == 4'h0;
  endfunction

  // rs2 is a source only for the register-register form (bit 11 clear).
  function automatic logic reads(input logic [15:0] i, input logic [2:0] r);
    return !is_nop(i) && ((i[7:5] == r) || (!i[11] && (i[4:2] == r)));
  endfunction

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= QDEPTH) s = s - QDEPTH;
    return PW'(s);
  endfunction

  logic [15:0]                     q [QDEPTH];
  logic [PW-1:0]                   head;
  logic [CW-1:0]                   count;
  logic [HIST_DEPTH-1:0][1:0]      hist_v;
  logic [HIST_DEPTH-1:0][1:0][2:0] hist_rd;

  logic [15:0]   h0, h1;
  logic          h0_haz, h1_haz;
  logic          iss0, iss1, stall_next;
  logic          accept, n0, n1;
  logic [1:0]    n_enq, deq;
  logic [15:0]   first;
  logic [PW-1:0] tail;

  assign in_ready = (count <= CW'(QDEPTH-2));
  assign q_count  = count;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    h0     = q[head];
    h1     = q[ptr_add(head, 1)];
    h0_haz = 1'b0;
    h1_haz = 1'b0;
    for (int s = 0; s < HIST_DEPTH; s++) begin
      for (int k = 0; k < 2; k++) begin
        if (hist_v[s][k]) begin
          h0_haz = h0_haz | reads(h0, hist_rd[s][k]);
          h1_haz = h1_haz | reads(h1, hist_rd[s][k]);
        end
      end
    end

    // Flush wins over dequeue: nothing issues on a flush edge.
    iss0 = !flush && (count != '0) && !h0_haz;
    iss1 = DUAL_EN && iss0 && (count >= CW'(2)) && !h1_haz
           && !reads(h1, h0[10:8]) && (h1[10:8] != h0[10:8]);
    stall_next = !flush && (count != '0) && h0_haz;
    deq = {1'b0, iss0} + {1'b0, iss1};

    accept = in_valid && in_ready && !flush;
    n0     = !is_nop(instr0_in);
    n1     = !is_nop(instr1_in);
    n_enq  = accept ? ({1'b0, n0} + {1'b0, n1}) : 2'd0;
    first  = n0 ? instr0_in : instr1_in;
    tail   = ptr_add(head, int'(count));
  end

  // NOTE: queue storage carries no reset; occupancy is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (n_enq != 2'd0) q[tail] <= first;
    if (n_enq == 2'd2) q[ptr_add(tail, 1)] <= instr1_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      count   <= '0;
      issue0  <= 16'h0;
      issue1  <= 16'h0;
      stall   <= 1'b0;
      hist_v  <= '0;
      hist_rd <= '0;
    end else begin
      for (int s = HIST_DEPTH-1; s > 0; s--) begin
        hist_v[s]  <= hist_v[s-1];
        hist_rd[s] <= hist_rd[s-1];
      end
      hist_v[0]     <= {iss1, iss0};
      hist_rd[0][0] <= h0[10:8];
      hist_rd[0][1] <= h1[10:8];

      issue0 <= iss0 ? h0 : 16'h0;
      issue1 <= iss1 ? h1 : 16'h0;
      stall  <= stall_next;
      if (flush) begin
        count <= '0;
      end else begin
        count <= count + CW'(n_enq) - CW'(deq);
        head  <= ptr_add(head, int'(deq));
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: directed vector table, corner
// sequences, and random traffic against a last-write-time reference model.
module tb_dual_issue_scheduler;

  localparam int HD = 3;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush;
  logic [15:0] instr0_in, instr1_in;
  logic        in_ready, stall;
  logic [15:0] issue0, issue1;
  logic [2:0]  q_count;

  logic        in_valid_s;
  logic [15:0] instr0_s, instr1_s;
  logic        in_ready_s, stall_s;
  logic [15:0] issue0_s, issue1_s;
  logic [2:0]  q_count_s;

  int total = 0;
  int bad   = 0;

  dual_issue_scheduler #(.HIST_DEPTH(HD), .QDEPTH(QD), .DUAL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr0_in(instr0_in), .instr1_in(instr1_in), .flush(flush),
    .issue0(issue0), .issue1(issue1), .stall(stall), .q_count(q_count)
  );

  dual_issue_scheduler #(.HIST_DEPTH(HD), .QDEPTH(QD), .DUAL_EN(1'b0)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .instr0_in(instr0_s), .instr1_in(instr1_s), .flush(1'b0),
    .issue0(issue0_s), .issue1(issue1_s), .stall(stall_s), .q_count(q_count_s)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic est, input int ecnt);
    check({tag, " issue0"}, issue0, e0);
    check({tag, " issue1"}, issue1, e1);
    check({tag, " stall"}, 16'(stall), 16'(est));
    check({tag, " q_count"}, 16'(q_count), 16'(ecnt));
  endtask

  task automatic apply(input logic v, input logic [15:0] a, input logic [15:0] b, input logic fl);
    in_valid  = v;
    instr0_in = a;
    instr1_in = b;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a register is busy if it was last issued as a
  // destination within the previous HD edges.
  logic [15:0] mq[$];
  int          lw[8];
  int          cyc;

  task automatic model_reset();
    mq.delete();
    for (int r = 0; r < 8; r++) lw[r] = -100;
    cyc = 0;
  endtask

  function automatic bit m_reads(input logic [15:0] x, input int r);
    return (int'(x[7:5]) == r) || (!x[11] && int'(x[4:2]) == r);
  endfunction

  function automatic bit m_blocked(input logic [15:0] x);
    for (int r = 0; r < 8; r++)
      if (m_reads(x, r) && lw[r] >= cyc - HD) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic fl, output logic [15:0] e0, output logic [15:0] e1,
                            output logic es);
    bit ready, go0, go1;
    logic [15:0] h0, h1;
    ready = (mq.size() <= QD-2);
    cyc++;
    e0 = 16'h0; e1 = 16'h0; es = 1'b0; go0 = 0; go1 = 0;
    if (fl) begin
      mq.delete();
    end else begin
      if (mq.size() > 0) begin
        h0 = mq[0];
        if (m_blocked(h0)) es = 1'b1;
        else begin
          go0 = 1;
          if (mq.size() > 1) begin
            h1 = mq[1];
            go1 = !m_blocked(h1) && !m_reads(h1, int'(h0[10:8])) && (h1[10:8] != h0[10:8]);
          end
        end
      end
      if (go0) begin e0 = h0; lw[h0[10:8]] = cyc; void'(mq.pop_front()); end
      if (go1) begin e1 = h1; lw[h1[10:8]] = cyc; void'(mq.pop_front()); end
      if (v && ready) begin
        if (a[15:12] != 4'h0) mq.push_back(a);
        if (b[15:12] != 4'h0) mq.push_back(b);
      end
    end
  endtask

  task automatic step(input string tag);
    logic [15:0] e0, e1;
    logic        es;
    check({tag, " in_ready"}, 16'(in_ready), 16'(mq.size() <= QD-2));
    @(posedge clk);
    model_edge(in_valid, instr0_in, instr1_in, flush, e0, e1, es);
    #1;
    expect_out(tag, e0, e1, es, mq.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; flush = 1'b0; instr0_in = 16'h0; instr1_in = 16'h0;
    in_valid_s = 1'b0; instr0_s = 16'h0; instr1_s = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    op = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    return {op, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
  endfunction

  typedef struct {
    logic        v;
    logic [15:0] a, b;
    logic [15:0] e0, e1;
    logic        est;
    int          ecnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [15:0] got[$];
    logic [15:0] pairs[4][2];
    logic [15:0] exp_order[8];
    int          idx;
    bit          saw_low, acc;

    tbl[0]  = '{1'b1, 16'h114C, 16'h164C, 16'h0000, 16'h0000, 1'b0, 2};
    tbl[1]  = '{1'b0, 16'h0000, 16'h0000, 16'h114C, 16'h164C, 1'b0, 0};
    tbl[2]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0};
    tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0};
    tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0};
    tbl[5]  = '{1'b1, 16'h114C, 16'h1434, 16'h0000, 16'h0000, 1'b0, 2};
    tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 16'h114C, 16'h0000, 1'b0, 1};
    tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1};
    tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1};
    tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 16'h1434, 16'h0000, 1'b0, 0};
    tbl[11] = '{1'b1, 16'h114C, 16'h1900, 16'h0000, 16'h0000, 1'b0, 2};
    tbl[12] = '{1'b0, 16'h0000, 16'h0000, 16'h114C, 16'h0000, 1'b0, 1};
    tbl[13] = '{1'b0, 16'h0000, 16'h0000, 16'h1900, 16'h0000, 1'b0, 0};

    rst = 1'b1;
    in_valid = 1'b0; flush = 1'b0; instr0_in = 16'h0; instr1_in = 16'h0;
    in_valid_s = 1'b0; instr0_s = 16'h0; instr1_s = 16'h0;
    #1;
    expect_out("reset", 16'h0, 16'h0, 1'b0, 0);
    check("reset in_ready", 16'(in_ready), 16'h1);
    do_reset();

    // Independent pair, RAW against history, WAW inside a pair.
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].v, tbl[i].a, tbl[i].b, 1'b0);
      expect_out($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].est, tbl[i].ecnt);
    end

    // Flush while the dependent instruction is stalled; history survives it.
    do_reset();
    apply(1'b1, 16'h114C, 16'h1434, 1'b0);
    apply(1'b0, 16'h0000, 16'h0000, 1'b0);
    expect_out("fl t", 16'h114C, 16'h0, 1'b0, 1);
    apply(1'b1, 16'h164C, 16'h164C, 1'b1);
    expect_out("fl t+1", 16'h0, 16'h0, 1'b0, 0);
    apply(1'b1, 16'h1434, 16'h0000, 1'b0);
    expect_out("fl t+2", 16'h0, 16'h0, 1'b0, 1);
    apply(1'b0, 16'h0000, 16'h0000, 1'b0);
    expect_out("fl t+3", 16'h0, 16'h0, 1'b1, 1);
    apply(1'b0, 16'h0000, 16'h0000, 1'b0);
    expect_out("fl t+4", 16'h1434, 16'h0, 1'b0, 0);

    // Single-issue build: the pair drains one per edge.
    do_reset();
    in_valid_s = 1'b1; instr0_s = 16'h114C; instr1_s = 16'h164C;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    check("se acc q_count", 16'(q_count_s), 16'd2);
    @(posedge clk); #1;
    check("se e1 issue0", issue0_s, 16'h114C);
    check("se e1 issue1", issue1_s, 16'h0);
    @(posedge clk); #1;
    check("se e2 issue0", issue0_s, 16'h164C);
    check("se e2 issue1", issue1_s, 16'h0);
    check("se e2 q_count", 16'(q_count_s), 16'd0);

    // Asynchronous reset in the middle of a stall.
    do_reset();
    apply(1'b1, 16'h114C, 16'h1434, 1'b0);
    apply(1'b0, 16'h0000, 16'h0000, 1'b0);
    apply(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("pre-rst stall", 16'(stall), 16'h1);
    #2 rst = 1'b1;
    #1;
    expect_out("mid rst", 16'h0, 16'h0, 1'b0, 0);
    check("mid rst in_ready", 16'(in_ready), 16'h1);
    @(posedge clk); #3;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Backpressure: fetch holds its pair until accepted; order must survive.
    pairs[0] = '{16'h114C, 16'h1434};
    for (int i = 1; i < 4; i++) pairs[i] = '{16'h1434, 16'h1434};
    exp_order[0] = 16'h114C;
    for (int i = 1; i < 8; i++) exp_order[i] = 16'h1434;
    idx = 0; saw_low = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (idx < 4);
      instr0_in = (idx < 4) ? pairs[idx][0] : 16'h0;
      instr1_in = (idx < 4) ? pairs[idx][1] : 16'h0;
      flush     = 1'b0;
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) saw_low = 1;
      step("bp");
      if (acc) idx++;
      if (issue0 != 16'h0) got.push_back(issue0);
      if (issue1 != 16'h0) got.push_back(issue1);
    end
    in_valid = 1'b0;
    check("bp in_ready fell", 16'(saw_low), 16'h1);
    check("bp issued count", 16'(got.size()), 16'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check($sformatf("bp order%0d", i), got[i], exp_order[i]);

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      instr0_in = rand_instr();
      instr1_in = rand_instr();
      flush     = ($urandom_range(0, 15) == 0);
      step($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

Clocked, parametrised successor to the fetch-stage relayer. It accepts instruction pairs from fetch into an in-order queue. Each cycle it issues up to two instructions from the queue head, checking RAW hazards against a configurable window of recently issued destinations and RAW/WAW hazards between the two slots. A blocked instruction stays in the queue, so no instruction is ever dropped or reordered. It sits between fetch and decode/register-read.

## Interface
- `HIST_DEPTH`, default 3: number of issue cycles during which an issued destination blocks a dependent source. Minimum 1.
- `QDEPTH`, default 4: queue entries. Minimum 2.
- `DUAL_EN`, default 1: 1 enables dual issue; 0 makes slot 1 always nop.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: fetch presents a pair.
- `in_ready` out 1: the pair is accepted on an edge where `in_valid && in_ready`.
- `instr0_in` in 16: older instruction of the pair.
- `instr1_in` in 16: younger instruction of the pair.
- `flush` in 1: synchronous queue clear.
- `issue0` out 16: registered issue slot 0, which is the older instruction. Nop = 16'h0.
- `issue1` out 16: registered issue slot 1, which is the younger instruction.
- `stall` out 1: registered. High when the queue was non-empty but the head could not issue.
- `q_count` out $clog2(QDEPTH+1): current queue occupancy.

## Operation
- **Instruction fields**
  - Opcode is [15:12]; opcode 0 = nop.
  - rd is [10:8].
  - rs1 is [7:5].
  - rs2 is [4:2], used only when [11]=0.
  - A nop has no source and no destination.
- **Enqueue**
  - Nops in the accepted pair are discarded; non-nops are packed in order, instr0 before instr1.
  - `in_ready = (q_count <= QDEPTH-2)`. It is computed from the current count, ignoring any same-cycle dequeue (conservative).
- **History**
  - Shift register of `HIST_DEPTH` stages. Each stage holds two {valid, rd} entries.
  - Every edge, the destinations issued at that edge shift into stage 0; a nop slot has valid=0.
  - The oldest stage is dropped.
  - History is not cleared by `flush`, because issued instructions are still in flight.
- **Issue (combinational select, registered output)**
  - Let H0 and H1 be the queue head and next entry.
  - H0 issues if the queue is non-empty and none of H0's sources match any valid history rd.
  - H1 issues if all of the following hold:
    - `DUAL_EN=1`;
    - H0 issues;
    - H1 exists;
    - H1 has no source hazard against history;
    - no H1 source equals H0.rd (RAW);
    - H1.rd != H0.rd (WAW).
  - Issued instructions leave the queue and load into `issue0`/`issue1`. Slots that do not issue load nop.
  - If H0 is blocked, both slots load nop and `stall` is set to 1. Otherwise `stall` is 0.
  - When the queue is empty, both outputs are nop and `stall` is 0.
- **Flush**
  - Takes priority over enqueue and dequeue.
  - At that edge the queue empties and outputs load nop. The pair presented in the same cycle is not accepted.
  - History still shifts, with invalid entries.
- **Reset**
  - Queue empty, all history invalid.
  - `issue0`=`issue1`=16'h0, `stall`=0, `q_count`=0, hence `in_ready`=1.
  - Reset is effective immediately, including mid-stall.

## Timing
- A pair accepted at edge k is head-eligible in cycle k+1. Its earliest issue is edge k+1, visible on the outputs after that edge.
- A producer issued at edge t occupies history stage 0 through stage `HIST_DEPTH-1` after edges t through t+HIST_DEPTH-1.
  - Its dependent consumer cannot issue at edges t+1..t+HIST_DEPTH.
  - The consumer issues at edge t+HIST_DEPTH+1 at the earliest.
  - `stall` is 1 for exactly `HIST_DEPTH` cycles if nothing else intervenes.
- Enqueue and dequeue in the same cycle: count' = count + enq − deq.
- When the queue is full, `in_ready`=0 and fetch must hold its pair.
- Throughput is at most 2 instructions per cycle when `DUAL_EN`=1, and 1 per cycle when `DUAL_EN`=0.

## Test plan
- **Independent pair.**
  - Stimulus: reset, then pair (0x114C, 0x164C).
  - Response: one edge after acceptance, issue0=0x114C, issue1=0x164C, stall=0, q_count=0.
- **RAW with history, HIST_DEPTH=3.**
  - Stimulus: pair (0x114C, 0x1434).
  - Response: 0x114C issues alone at edge t. Over the next 3 edges: issue0=0, issue1=0, stall=1. At edge t+4: issue0=0x1434, stall=0.
- **WAW within pair.**
  - Stimulus: pair (0x114C, 0x1900).
  - Response: 0x114C issues at edge t; 0x1900 issues as issue0 at edge t+1 (rs1=0 is not hazarded).
- **Backpressure.**
  - Stimulus: feed (0x114C, 0x1434) followed by three pairs of (0x1434, 0x1434) with `in_valid` held high.
  - Response: `in_ready` falls once q_count ≥ 3. No instruction is lost or duplicated, and issue order matches fetch order.
- **Flush during stall.**
  - Stimulus: in the RAW scenario, assert `flush` at edge t+1.
  - Response: q_count=0 and outputs nop after that edge. A new pair containing rs1=1 still stalls until edge t+4.
- **DUAL_EN=0 and reset mid-operation.**
  - Stimulus: independent pair (0x114C, 0x164C); separately, assert `rst` mid-stall.
  - Response: with `DUAL_EN=0`, the pair issues on consecutive edges and issue1 stays 0. On reset, all outputs return immediately to 0 and `in_ready`=1.
